// File: rtl/cpu_clock_controller.sv
// cpu_clock_controller
//   Generates the 68000 CPU clock from the 40 MHz system clock using a
//   programmable half-period divisor. Supports glitch-free divisor changes
//   (applied only at a falling edge of CLK_OUT), halting with CLK_OUT low
//   after a full-length low phase, and single-stepping one CPU clock period.
//
// Ports:
//   CLK        in   system clock
//   RESET      in   synchronous active-high reset
//   DIV_WR     in   strobe: DIV_DATA becomes the pending divisor
//   DIV_DATA   in   new half-period divisor (half period = DIV+1 cycles)
//   MODE_WR    in   strobe: mode command on MODE_DATA
//   MODE_DATA  in   0=RUN, 1=HALT, 2/3 ignored
//   STEP_REQ   in   level request for one CPU clock period while halted
//   STEP_ACK   out  one-cycle pulse when a step completes
//   CLK_OUT    out  generated CPU clock (registered)
//   CLK_RISE   out  high in the cycle CLK_OUT becomes 1
//   CLK_FALL   out  high in the cycle CLK_OUT becomes 0
//   HALTED     out  high while in the HALT state
//   BUSY       out  a divisor change is pending
//   CUR_DIV    out  active divisor
module cpu_clock_controller #(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 DIV_WR,
  input  logic [DIV_WIDTH-1:0] DIV_DATA,
  input  logic                 MODE_WR,
  input  logic [1:0]           MODE_DATA,
  input  logic                 STEP_REQ,
  output logic                 STEP_ACK,
  output logic                 CLK_OUT,
  output logic                 CLK_RISE,
  output logic                 CLK_FALL,
  output logic                 HALTED,
  output logic                 BUSY,
  output logic [DIV_WIDTH-1:0] CUR_DIV
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALT    = 2'd1,
    ST_STEP_HI = 2'd2,
    ST_STEP_LO = 2'd3
  } state_t;

  localparam logic [DIV_WIDTH-1:0] RESET_DIV = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1);

  state_t                 state_reg,     state_next;
  logic [DIV_WIDTH-1:0]   count_reg,     count_next;
  logic [DIV_WIDTH-1:0]   cur_div_reg,   cur_div_next;
  logic [DIV_WIDTH-1:0]   pend_div_reg,  pend_div_next;
  logic                   busy_reg,      busy_next;
  logic                   clk_out_reg,   clk_out_next;
  logic                   rise_reg,      rise_next;
  logic                   fall_reg,      fall_next;
  logic                   ack_reg,       ack_next;
  logic                   halt_pend_reg, halt_pend_next;
  logic                   run_pend_reg,  run_pend_next;

  logic toggle;
  logic mode_run;
  logic mode_halt;

  assign toggle    = (count_reg == cur_div_reg);
  assign mode_run  = MODE_WR && (MODE_DATA == 2'd0);
  assign mode_halt = MODE_WR && (MODE_DATA == 2'd1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= ST_RUN;
      count_reg     <= '0;
      cur_div_reg   <= RESET_DIV;
      pend_div_reg  <= RESET_DIV;
      busy_reg      <= 1'b0;
      clk_out_reg   <= 1'b0;
      rise_reg      <= 1'b0;
      fall_reg      <= 1'b0;
      ack_reg       <= 1'b0;
      halt_pend_reg <= 1'b0;
      run_pend_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      cur_div_reg   <= cur_div_next;
      pend_div_reg  <= pend_div_next;
      busy_reg      <= busy_next;
      clk_out_reg   <= clk_out_next;
      rise_reg      <= rise_next;
      fall_reg      <= fall_next;
      ack_reg       <= ack_next;
      halt_pend_reg <= halt_pend_next;
      run_pend_reg  <= run_pend_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    cur_div_next   = cur_div_reg;
    pend_div_next  = pend_div_reg;
    busy_next      = busy_reg;
    clk_out_next   = clk_out_reg;
    rise_next      = 1'b0;
    fall_next      = 1'b0;
    ack_next       = 1'b0;
    halt_pend_next = halt_pend_reg;
    run_pend_next  = run_pend_reg;

    case (state_reg)
      ST_RUN: begin
        if (mode_run) begin
          halt_pend_next = 1'b0;
        end else if (mode_halt) begin
          halt_pend_next = 1'b1;
        end
        if (toggle) begin
          count_next = '0;
          if (clk_out_reg) begin
            clk_out_next = 1'b0;
            fall_next    = 1'b1;
            // Divisor only changes at a falling edge so no phase is truncated.
            if (busy_reg) begin
              cur_div_next = pend_div_reg;
              busy_next    = 1'b0;
            end
          end else if (halt_pend_reg) begin
            // Suppress the rise: the low phase just completed at full length.
            state_next     = ST_HALT;
            halt_pend_next = 1'b0;
          end else begin
            clk_out_next = 1'b1;
            rise_next    = 1'b1;
          end
        end else begin
          count_next = count_reg + ONE;
        end
      end

      ST_HALT: begin
        count_next   = '0;
        clk_out_next = 1'b0;
        // No clock is running, so a divisor change can take effect at once.
        if (DIV_WR) begin
          cur_div_next = DIV_DATA;
        end else if (busy_reg) begin
          cur_div_next = pend_div_reg;
        end
        busy_next = 1'b0;
        if (mode_run) begin
          state_next = ST_RUN;
        end else if (STEP_REQ && !ack_reg) begin
          // STEP_REQ is ignored in the ack cycle so the requester can drop it.
          state_next   = ST_STEP_HI;
          clk_out_next = 1'b1;
          rise_next    = 1'b1;
        end
      end

      ST_STEP_HI: begin
        if (mode_run) begin
          run_pend_next = 1'b1;
        end
        if (toggle) begin
          count_next   = '0;
          clk_out_next = 1'b0;
          fall_next    = 1'b1;
          state_next   = ST_STEP_LO;
          if (busy_reg) begin
            cur_div_next = pend_div_reg;
            busy_next    = 1'b0;
          end
        end else begin
          count_next = count_reg + ONE;
        end
      end

      ST_STEP_LO: begin
        if (mode_run) begin
          run_pend_next = 1'b1;
        end
        if (toggle) begin
          count_next    = '0;
          ack_next      = 1'b1;
          run_pend_next = 1'b0;
          state_next    = (run_pend_reg || mode_run) ? ST_RUN : ST_HALT;
        end else begin
          count_next = count_reg + ONE;
        end
      end

      default: begin
        state_next = ST_RUN;
      end
    endcase

    // A write outside HALT always (re)loads the pending slot, last one wins;
    // if it coincides with an application, the newer value stays pending.
    if (DIV_WR && (state_reg != ST_HALT)) begin
      pend_div_next = DIV_DATA;
      busy_next     = 1'b1;
    end
  end

  assign STEP_ACK = ack_reg;
  assign CLK_OUT  = clk_out_reg;
  assign CLK_RISE = rise_reg;
  assign CLK_FALL = fall_reg;
  assign HALTED   = (state_reg == ST_HALT);
  assign BUSY     = busy_reg;
  assign CUR_DIV  = cur_div_reg;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Directed testbench for cpu_clock_controller (DIV_WIDTH=8, DEFAULT_DIV=0).
module tb_cpu_clock_controller;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       DIV_WR;
  logic [7:0] DIV_DATA;
  logic       MODE_WR;
  logic [1:0] MODE_DATA;
  logic       STEP_REQ;
  logic       STEP_ACK;
  logic       CLK_OUT;
  logic       CLK_RISE;
  logic       CLK_FALL;
  logic       HALTED;
  logic       BUSY;
  logic [7:0] CUR_DIV;

  int total = 0;
  int bad   = 0;

  cpu_clock_controller #(.DIV_WIDTH(8), .DEFAULT_DIV(0)) dut (
    .CLK(CLK), .RESET(RESET), .DIV_WR(DIV_WR), .DIV_DATA(DIV_DATA),
    .MODE_WR(MODE_WR), .MODE_DATA(MODE_DATA), .STEP_REQ(STEP_REQ),
    .STEP_ACK(STEP_ACK), .CLK_OUT(CLK_OUT), .CLK_RISE(CLK_RISE),
    .CLK_FALL(CLK_FALL), .HALTED(HALTED), .BUSY(BUSY), .CUR_DIV(CUR_DIV)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Length of the current run of CLK_OUT==lvl, starting with this cycle.
  task automatic measure(input logic lvl, output int n);
    n = 0;
    while (CLK_OUT === lvl && n < 600) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n, hi, rises, falls, acks, ack_at;
    RESET = 1'b1; DIV_WR = 1'b0; DIV_DATA = '0;
    MODE_WR = 1'b0; MODE_DATA = '0; STEP_REQ = 1'b0;

    // 1: reset values, then divide-by-one toggling
    tick(); tick();
    $display("step 1: reset state and div=0 toggling");
    chk("rst_clk_out", CLK_OUT, 0);
    chk("rst_rise", CLK_RISE, 0);
    chk("rst_fall", CLK_FALL, 0);
    chk("rst_ack", STEP_ACK, 0);
    chk("rst_halted", HALTED, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_cur_div", CUR_DIV, 0);
    RESET = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t1_clk_out", CLK_OUT, (i % 2 == 0) ? 1 : 0);
      chk("t1_rise", CLK_RISE, (i % 2 == 0) ? 1 : 0);
      chk("t1_fall", CLK_FALL, (i % 2 == 0) ? 0 : 1);
    end

    // 2: divisor 19 written while CLK_OUT=1 waits for the next fall
    $display("step 2: DIV_WR=19 while high");
    DIV_WR = 1'b1; DIV_DATA = 8'd19;
    tick();
    DIV_WR = 1'b0;
    chk("t2_busy_a", BUSY, 1);
    chk("t2_div_a", CUR_DIV, 0);
    tick();
    chk("t2_busy_b", BUSY, 1);
    chk("t2_clk_b", CLK_OUT, 1);
    tick();
    chk("t2_fall", CLK_FALL, 1);
    chk("t2_div_c", CUR_DIV, 19);
    chk("t2_busy_c", BUSY, 0);
    measure(1'b0, n); chk("t2_low_len", n, 20);
    measure(1'b1, n); chk("t2_high_len", n, 20);

    // 3: switch to divisor 3, then halt while high at COUNT=1
    $display("step 3: div=3 then halt mid high phase");
    DIV_WR = 1'b1; DIV_DATA = 8'd3;
    tick();
    DIV_WR = 1'b0;
    chk("t3_busy", BUSY, 1);
    measure(1'b0, n); chk("t3_low_rest", n, 19);
    measure(1'b1, n); chk("t3_high_old", n, 20);
    chk("t3_div", CUR_DIV, 3);
    chk("t3_busy_clr", BUSY, 0);
    measure(1'b0, n); chk("t3_low_len", n, 4);
    measure(1'b1, n); chk("t3_high_len", n, 4);
    repeat (4) tick();
    chk("t3_rise", CLK_RISE, 1);
    tick();                                   // COUNT=1, high
    MODE_WR = 1'b1; MODE_DATA = 2'd1;
    tick();
    MODE_WR = 1'b0;
    chk("t3_still_high", CLK_OUT, 1);
    tick();
    chk("t3_still_high2", CLK_OUT, 1);
    tick();
    chk("t3_halt_fall", CLK_FALL, 1);
    repeat (3) tick();
    chk("t3_low_not_halted", HALTED, 0);
    chk("t3_low_clk", CLK_OUT, 0);
    tick();
    chk("t3_halted", HALTED, 1);
    chk("t3_halt_clk", CLK_OUT, 0);
    rises = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      rises += int'(CLK_RISE) + int'(CLK_OUT);
    end
    chk("t3_no_rise", rises, 0);

    // 4: single step with divisor 3
    $display("step 4: single step");
    STEP_REQ = 1'b1;
    tick();
    STEP_REQ = 1'b0;
    chk("t4_start_clk", CLK_OUT, 1);
    chk("t4_start_rise", CLK_RISE, 1);
    hi = 0; rises = 0; falls = 0; acks = 0; ack_at = -1;
    for (int i = 0; i < 12; i++) begin
      hi    += int'(CLK_OUT);
      rises += int'(CLK_RISE);
      falls += int'(CLK_FALL);
      acks  += int'(STEP_ACK);
      if (STEP_ACK) ack_at = i;
      tick();
    end
    chk("t4_high_cycles", hi, 4);
    chk("t4_rises", rises, 1);
    chk("t4_falls", falls, 1);
    chk("t4_acks", acks, 1);
    chk("t4_ack_cycle", ack_at, 8);
    chk("t4_halted", HALTED, 1);
    chk("t4_clk", CLK_OUT, 0);

    // 5: divisor write and RUN together while halted
    $display("step 5: DIV_WR=7 with MODE_WR=RUN while halted");
    DIV_WR = 1'b1; DIV_DATA = 8'd7; MODE_WR = 1'b1; MODE_DATA = 2'd0;
    tick();
    DIV_WR = 1'b0; MODE_WR = 1'b0;
    chk("t5_div", CUR_DIV, 7);
    chk("t5_halted", HALTED, 0);
    chk("t5_busy", BUSY, 0);
    measure(1'b0, n); chk("t5_first_low", n, 8);
    chk("t5_rise", CLK_RISE, 1);
    measure(1'b1, n); chk("t5_high_len", n, 8);
    measure(1'b0, n); chk("t5_low_len", n, 8);

    // 6: reset during STEP_HI with a pending divisor
    $display("step 6: reset mid-step with BUSY");
    MODE_WR = 1'b1; MODE_DATA = 2'd1;
    tick();
    MODE_WR = 1'b0;
    n = 0;
    while (!HALTED && n < 40) begin
      n++;
      tick();
    end
    chk("t6_halted", HALTED, 1);
    STEP_REQ = 1'b1;
    tick();
    STEP_REQ = 1'b0;
    chk("t6_step_hi", CLK_OUT, 1);
    DIV_WR = 1'b1; DIV_DATA = 8'd5;
    tick();
    DIV_WR = 1'b0;
    chk("t6_busy", BUSY, 1);
    chk("t6_div_kept", CUR_DIV, 7);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("t6_clk", CLK_OUT, 0);
    chk("t6_halted_clr", HALTED, 0);
    chk("t6_div", CUR_DIV, 0);
    chk("t6_busy_clr", BUSY, 0);
    chk("t6_ack", STEP_ACK, 0);
    acks = 0; rises = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      acks  += int'(STEP_ACK);
      rises += int'(CLK_RISE);
    end
    chk("t6_no_ack", acks, 0);
    chk("t6_run_rises", rises, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
